// File: rtl/rv32i_trap_ctrl.sv
// Machine-mode trap entry/return sequencer for an RV32I pipeline.
// Accepts exceptions from decode and masked external interrupts. It stalls
// and flushes the pipeline, then waits for outstanding memory accesses to
// drain. For a trap it writes mepc, mcause and mtval one per cycle and
// redirects fetch to mtvec. For MRET it skips the CSR writes and redirects
// fetch to mepc.
module rv32i_trap_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_is_inst_illegal,
  input  logic        i_is_ecall,
  input  logic        i_is_ebreak,
  input  logic        i_is_mret,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_irq_pending,
  input  logic        i_mstatus_mie,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic        i_pipe_idle,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_csr_we,
  output logic [11:0] o_csr_addr,
  output logic [31:0] o_csr_wdata,
  output logic        o_mstatus_trap,
  output logic        o_mstatus_mret,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_WR_MEPC,
    S_WR_MCAUSE,
    S_WR_MTVAL,
    S_REDIRECT
  } state_t;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  state_t      state_q, state_d;
  logic [31:0] pc_q, cause_q, tval_q;
  logic        is_mret_q;
  logic        busy_q;

  logic        irq_take;
  logic        any_event;
  logic        take;
  logic [31:0] cause_d, tval_d;
  logic        is_mret_d;

  // Mode bits of mtvec/mepc are dropped; only the aligned base is used.
  logic unused_low_bits;
  assign unused_low_bits = ^{i_mtvec[1:0], i_mepc[1:0]};

  // Prioritise the incoming event and work out its cause and tval.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    cause_d   = '0;
    tval_d    = '0;
    is_mret_d = 1'b0;
    any_event = 1'b1;
    irq_take  = i_irq_pending & i_mstatus_mie;
    if (irq_take) begin
      cause_d = CAUSE_MEI;
    end else if (i_is_inst_illegal) begin
      cause_d = CAUSE_ILLEGAL;
      tval_d  = i_inst;
    end else if (i_is_ebreak) begin
      cause_d = CAUSE_BREAK;
      tval_d  = i_pc;
    end else if (i_is_ecall) begin
      cause_d = CAUSE_ECALL_M;
    end else if (i_is_mret) begin
      is_mret_d = 1'b1;
    end else begin
      any_event = 1'b0;
    end
  end

  // A take only happens from IDLE on a valid instruction. Gating with reset
  // keeps the combinational flush/stall low while reset is held.
  assign take = i_rst_n & (state_q == S_IDLE) & i_valid & any_event;

  // Next-state logic for the trap sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (take) state_d = S_DRAIN;
      S_DRAIN:     if (i_pipe_idle) state_d = is_mret_q ? S_REDIRECT : S_WR_MEPC;
      S_WR_MEPC:   state_d = S_WR_MCAUSE;
      S_WR_MCAUSE: state_d = S_WR_MTVAL;
      S_WR_MTVAL:  state_d = S_REDIRECT;
      S_REDIRECT:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register, busy flag and the latched trap context.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all registers here are few and control-relevant, so they all take the async reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      is_mret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      if (take) begin
        pc_q      <= i_pc;
        cause_q   <= cause_d;
        tval_q    <= tval_d;
        is_mret_q <= is_mret_d;
      end
    end
  end

  // Output decode: the CSR write port, mstatus pulses and the fetch redirect.
  always_comb begin
    o_csr_we       = 1'b0;
    o_csr_addr     = '0;
    o_csr_wdata    = '0;
    o_mstatus_trap = 1'b0;
    o_mstatus_mret = 1'b0;
    o_redirect     = 1'b0;
    o_redirect_pc  = '0;
    case (state_q)
      S_WR_MEPC: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MEPC;
        o_csr_wdata = pc_q;
      end
      S_WR_MCAUSE: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MCAUSE;
        o_csr_wdata = cause_q;
      end
      S_WR_MTVAL: begin
        o_csr_we       = 1'b1;
        o_csr_addr     = CSR_MTVAL;
        o_csr_wdata    = tval_q;
        o_mstatus_trap = 1'b1;
      end
      S_REDIRECT: begin
        o_redirect = 1'b1;
        if (is_mret_q) begin
          o_redirect_pc  = {i_mepc[31:2], 2'b00};
          o_mstatus_mret = 1'b1;
        end else begin
          o_redirect_pc  = {i_mtvec[31:2], 2'b00};
        end
      end
      default: ;
    endcase
  end

  assign o_flush = take;
  assign o_busy  = busy_q;
  assign o_stall = take | busy_q;

endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// Directed bench for rv32i_trap_ctrl. A table of trap/MRET vectors is run
// through the full cycle-by-cycle sequence. Hand-written sequences cover
// ignored flags and a reset during the sequence.
module tb_rv32i_trap_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_is_inst_illegal, i_is_ecall, i_is_ebreak, i_is_mret;
  logic [31:0] i_inst, i_pc;
  logic        i_irq_pending, i_mstatus_mie;
  logic [31:0] i_mtvec, i_mepc;
  logic        i_pipe_idle;
  logic        o_stall, o_flush, o_csr_we;
  logic [11:0] o_csr_addr;
  logic [31:0] o_csr_wdata;
  logic        o_mstatus_trap, o_mstatus_mret, o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  rv32i_trap_ctrl dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_valid          (i_valid),
    .i_is_inst_illegal(i_is_inst_illegal),
    .i_is_ecall       (i_is_ecall),
    .i_is_ebreak      (i_is_ebreak),
    .i_is_mret        (i_is_mret),
    .i_inst           (i_inst),
    .i_pc             (i_pc),
    .i_irq_pending    (i_irq_pending),
    .i_mstatus_mie    (i_mstatus_mie),
    .i_mtvec          (i_mtvec),
    .i_mepc           (i_mepc),
    .i_pipe_idle      (i_pipe_idle),
    .o_stall          (o_stall),
    .o_flush          (o_flush),
    .o_csr_we         (o_csr_we),
    .o_csr_addr       (o_csr_addr),
    .o_csr_wdata      (o_csr_wdata),
    .o_mstatus_trap   (o_mstatus_trap),
    .o_mstatus_mret   (o_mstatus_mret),
    .o_redirect       (o_redirect),
    .o_redirect_pc    (o_redirect_pc),
    .o_busy           (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        illegal, ecall, ebreak, mret, irq, mie;
    logic [31:0] inst, pc, mtvec, mepc;
    int          drain_wait;
    logic        noise;
    logic        exp_mret;
    logic [31:0] exp_cause, exp_tval, exp_rpc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"},    {31'b0, o_stall},        32'd0);
    check({tag, " flush"},    {31'b0, o_flush},        32'd0);
    check({tag, " csr_we"},   {31'b0, o_csr_we},       32'd0);
    check({tag, " csr_addr"}, {20'b0, o_csr_addr},     32'd0);
    check({tag, " csr_wdata"}, o_csr_wdata,            32'd0);
    check({tag, " trap"},     {31'b0, o_mstatus_trap}, 32'd0);
    check({tag, " mret"},     {31'b0, o_mstatus_mret}, 32'd0);
    check({tag, " redirect"}, {31'b0, o_redirect},     32'd0);
    check({tag, " rpc"},      o_redirect_pc,           32'd0);
    check({tag, " busy"},     {31'b0, o_busy},         32'd0);
  endtask

  task automatic clear_inputs();
    i_valid = 1'b0;
    i_is_inst_illegal = 1'b0;
    i_is_ecall = 1'b0;
    i_is_ebreak = 1'b0;
    i_is_mret = 1'b0;
    i_irq_pending = 1'b0;
    i_mstatus_mie = 1'b0;
    i_inst = '0;
    i_pc = '0;
  endtask

  // Flags hammered while the controller is busy; none may start a new take.
  task automatic apply_noise();
    i_valid = 1'b1;
    i_is_inst_illegal = 1'b1;
    i_is_ecall = 1'b1;
    i_is_ebreak = 1'b1;
    i_is_mret = 1'b1;
    i_irq_pending = 1'b1;
    i_mstatus_mie = 1'b1;
    i_inst = 32'h1234_5678;
    i_pc = 32'hDEAD_BEE0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    @(negedge i_clk);
    check({tag, " idle stall"},    {31'b0, o_stall},    32'd0);
    check({tag, " idle busy"},     {31'b0, o_busy},     32'd0);
    check({tag, " idle redirect"}, {31'b0, o_redirect}, 32'd0);
    check({tag, " idle csr_we"},   {31'b0, o_csr_we},   32'd0);
    next_cycle();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    logic [11:0] addrs[3];
    logic [31:0] datas[3];
    t = $sformatf("v%0d", idx);
    addrs[0] = 12'h341; addrs[1] = 12'h342; addrs[2] = 12'h343;
    datas[0] = v.pc;    datas[1] = v.exp_cause; datas[2] = v.exp_tval;
    // C0: take cycle
    i_valid = 1'b1;
    i_is_inst_illegal = v.illegal;
    i_is_ecall = v.ecall;
    i_is_ebreak = v.ebreak;
    i_is_mret = v.mret;
    i_irq_pending = v.irq;
    i_mstatus_mie = v.mie;
    i_inst = v.inst;
    i_pc = v.pc;
    i_mtvec = v.mtvec;
    i_mepc = v.mepc;
    i_pipe_idle = (v.drain_wait == 0);
    @(negedge i_clk);
    check({t, " C0 flush"},    {31'b0, o_flush},    32'd1);
    check({t, " C0 stall"},    {31'b0, o_stall},    32'd1);
    check({t, " C0 busy"},     {31'b0, o_busy},     32'd0);
    check({t, " C0 csr_we"},   {31'b0, o_csr_we},   32'd0);
    check({t, " C0 redirect"}, {31'b0, o_redirect}, 32'd0);
    next_cycle();
    if (v.noise) apply_noise(); else clear_inputs();
    // DRAIN: one cycle plus one per cycle of pipe not idle
    for (int k = 0; k <= v.drain_wait; k++) begin
      i_pipe_idle = (k == v.drain_wait);
      @(negedge i_clk);
      check($sformatf("%s drain%0d busy", t, k),     {31'b0, o_busy},     32'd1);
      check($sformatf("%s drain%0d stall", t, k),    {31'b0, o_stall},    32'd1);
      check($sformatf("%s drain%0d flush", t, k),    {31'b0, o_flush},    32'd0);
      check($sformatf("%s drain%0d csr_we", t, k),   {31'b0, o_csr_we},   32'd0);
      check($sformatf("%s drain%0d redirect", t, k), {31'b0, o_redirect}, 32'd0);
      next_cycle();
    end
    i_pipe_idle = 1'b1;
    if (!v.exp_mret) begin
      for (int w = 0; w < 3; w++) begin
        @(negedge i_clk);
        check($sformatf("%s wr%0d csr_we", t, w), {31'b0, o_csr_we}, 32'd1);
        check($sformatf("%s wr%0d addr", t, w),   {20'b0, o_csr_addr}, {20'b0, addrs[w]});
        check($sformatf("%s wr%0d wdata", t, w),  o_csr_wdata, datas[w]);
        check($sformatf("%s wr%0d trap", t, w),   {31'b0, o_mstatus_trap}, {31'b0, (w == 2)});
        check($sformatf("%s wr%0d stall", t, w),  {31'b0, o_stall}, 32'd1);
        check($sformatf("%s wr%0d flush", t, w),  {31'b0, o_flush}, 32'd0);
        next_cycle();
      end
    end
    clear_inputs();
    @(negedge i_clk);
    check({t, " rd redirect"}, {31'b0, o_redirect},     32'd1);
    check({t, " rd pc"},       o_redirect_pc,           v.exp_rpc);
    check({t, " rd mret"},     {31'b0, o_mstatus_mret}, {31'b0, v.exp_mret});
    check({t, " rd trap"},     {31'b0, o_mstatus_trap}, 32'd0);
    check({t, " rd csr_we"},   {31'b0, o_csr_we},       32'd0);
    check({t, " rd stall"},    {31'b0, o_stall},        32'd1);
    check({t, " rd busy"},     {31'b0, o_busy},         32'd1);
    next_cycle();
  endtask

  initial begin
    // Vector table with hand-computed expectations
    vecs[0] = '{default: 0, illegal: 1'b1, inst: 32'hFFFF_FFFF, pc: 32'h100, mtvec: 32'h200,
                exp_cause: 32'd2, exp_tval: 32'hFFFF_FFFF, exp_rpc: 32'h200};
    vecs[1] = '{default: 0, ecall: 1'b1, inst: 32'h0000_0073, pc: 32'h40, mtvec: 32'h303,
                drain_wait: 3, exp_cause: 32'd11, exp_tval: 32'd0, exp_rpc: 32'h300};
    vecs[2] = '{default: 0, mret: 1'b1, inst: 32'h3020_0073, pc: 32'h88, mtvec: 32'h200,
                mepc: 32'h1236, exp_mret: 1'b1, exp_rpc: 32'h1234};
    vecs[3] = '{default: 0, ebreak: 1'b1, irq: 1'b1, mie: 1'b1, pc: 32'h80, mtvec: 32'h200,
                exp_cause: 32'h8000_000B, exp_tval: 32'd0, exp_rpc: 32'h200};
    vecs[4] = '{default: 0, ebreak: 1'b1, irq: 1'b1, mie: 1'b0, pc: 32'h80, mtvec: 32'h200,
                exp_cause: 32'd3, exp_tval: 32'h80, exp_rpc: 32'h200};
    vecs[5] = '{default: 0, illegal: 1'b1, ecall: 1'b1, ebreak: 1'b1, inst: 32'hABCD_0001,
                pc: 32'h500, mtvec: 32'h2000_0001, exp_cause: 32'd2, exp_tval: 32'hABCD_0001,
                exp_rpc: 32'h2000_0000};
    vecs[6] = '{default: 0, ecall: 1'b1, mret: 1'b1, pc: 32'h600, mtvec: 32'h700,
                mepc: 32'h900, drain_wait: 1, exp_cause: 32'd11, exp_tval: 32'd0, exp_rpc: 32'h700};
    vecs[7] = '{default: 0, mret: 1'b1, irq: 1'b1, mie: 1'b1, pc: 32'h10, mtvec: 32'h400,
                mepc: 32'h500, exp_cause: 32'h8000_000B, exp_tval: 32'd0, exp_rpc: 32'h400};
    vecs[8] = '{default: 0, illegal: 1'b1, inst: 32'h0000_0000, pc: 32'hC0, mtvec: 32'h200,
                drain_wait: 1, noise: 1'b1, exp_cause: 32'd2, exp_tval: 32'd0, exp_rpc: 32'h200};

    // Reset state
    i_rst_n = 1'b0;
    clear_inputs();
    i_mtvec = '0;
    i_mepc = '0;
    i_pipe_idle = 1'b1;
    #3;
    check_all_zero("reset");
    #9 i_rst_n = 1'b1;
    next_cycle();
    idle_check("post_reset");

    // Flags with i_valid=0 must not start a sequence
    apply_noise();
    i_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check($sformatf("novalid%0d flush", c), {31'b0, o_flush}, 32'd0);
      check($sformatf("novalid%0d stall", c), {31'b0, o_stall}, 32'd0);
      check($sformatf("novalid%0d busy", c),  {31'b0, o_busy},  32'd0);
      next_cycle();
    end
    clear_inputs();

    // Table-driven sequences; odd entries run back-to-back into the next take
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      if (i % 2 == 0) idle_check($sformatf("v%0d", i));
    end
    idle_check("tail");

    // Reset during WR_MEPC aborts the sequence asynchronously
    i_valid = 1'b1;
    i_is_inst_illegal = 1'b1;
    i_inst = 32'hFFFF_FFFF;
    i_pc = 32'h100;
    i_mtvec = 32'h200;
    i_pipe_idle = 1'b1;
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge i_clk);
    check("rstmid pre csr_we", {31'b0, o_csr_we}, 32'd1);
    check("rstmid pre addr",   {20'b0, o_csr_addr}, 32'h341);
    #1 i_rst_n = 1'b0;
    #1 check_all_zero("rstmid");
    @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    for (int c = 0; c < 5; c++) idle_check($sformatf("rstmid after%0d", c));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
